maj_chain_checker: RTL and testbench

MAJ_CHAIN_CHECKER -- requirements
Module: maj_chain_checker

---
 rtl/maj_chain_checker.sv | 233 +++++++++++++++++++++++
 tb/tb_maj_chain_checker.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maj_chain_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : maj_chain_checker                                            |
// | Description : Loads a chain of up to MAX_GATES 3-input majority gates      |
// |               over inputs x3..x0 and checks the selected netlist output    |
// |               against a 16-entry truth table, one minterm per cycle.       |
// |               Optional: define MAJ_CHECK_CEX_EN to capture the first       |
// |               failing minterm on cex_valid / cex_idx.                      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module maj_chain_checker #(
  parameter int MAX_GATES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] tt,
  input  logic [3:0]  out_sel,
  input  logic        out_inv,
  input  logic        gate_valid,
  output logic        gate_ready,
  input  logic [14:0] gate_data,
  input  logic        gate_last,
  output logic        busy,
  output logic        done,
  output logic        match,
  output logic        err,
  output logic [3:0]  n_gates,
  output logic        cex_valid,
  output logic [3:0]  cex_idx
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EVAL = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] tt_q, tt_d;
  logic [3:0]  out_sel_q, out_sel_d;
  logic        out_inv_q, out_inv_d;
  logic [3:0]  n_gates_q, n_gates_d;
  logic [3:0]  m_q, m_d;
  logic        run_match_q, run_match_d;
  logic        match_q, match_d;
  logic        err_q, err_d;
  logic [14:0] gates_q [8];
  logic [14:0] gates_d [8];

  logic        out_val;
  logic        mismatch;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Operand {inv, idx}: 0..3 primary inputs, 4..11 gate outputs, 12..15 zero.
  function automatic logic operand_val(input logic [4:0] op, input logic [3:0] x,
                                       input logic [7:0] g);
    logic [3:0] gi;
    logic       v;
    gi = op[3:0] - 4'd4;
    v  = 1'b0;
    if (op[3:0] < 4'd4) begin
      v = x[op[1:0]];
    end else if (op[3:0] < 4'd12) begin
      v = g[gi[2:0]];
    end
    return v ^ op[4];
  endfunction

  // True when an operand names gate k itself or any gate after it.
  function automatic logic fwd_ref(input logic [4:0] op, input logic [3:0] k);
    return (op[3:0] >= 4'd4) && (op[3:0] < 4'd12) &&
           ({1'b0, op[3:0]} >= ({1'b0, k} + 5'd4));
  endfunction

  // Evaluate every gate for the current minterm, lower index first, then the output.
  always_comb begin : p_eval
    logic [7:0] gv;
    gv = '0;
    for (int j = 0; j < 8; j++) begin
      if (j < MAX_GATES) begin
        gv[j] = maj3(operand_val(gates_q[j][4:0],   m_q, gv),
                     operand_val(gates_q[j][9:5],   m_q, gv),
                     operand_val(gates_q[j][14:10], m_q, gv));
      end
    end
    out_val  = operand_val({out_inv_q, out_sel_q}, m_q, gv);
    mismatch = out_val ^ tt_q[m_q];
  end

  // Next-state and datapath updates for the IDLE/LOAD/EVAL/DONE sequence.
  always_comb begin
    state_d     = state_q;
    tt_d        = tt_q;
    out_sel_d   = out_sel_q;
    out_inv_d   = out_inv_q;
    n_gates_d   = n_gates_q;
    m_d         = m_q;
    run_match_d = run_match_q;
    match_d     = match_q;
    err_d       = err_q;
    gates_d     = gates_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          tt_d        = tt;
          out_sel_d   = out_sel;
          out_inv_d   = out_inv;
          n_gates_d   = 4'd0;
          m_d         = 4'd0;
          run_match_d = 1'b1;
          match_d     = 1'b0;
          err_d       = 1'b0;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        if (gate_valid) begin
          gates_d[n_gates_q[2:0]] = gate_data;
          n_gates_d = n_gates_q + 4'd1;
          if (fwd_ref(gate_data[4:0], n_gates_q) || fwd_ref(gate_data[9:5], n_gates_q) ||
              fwd_ref(gate_data[14:10], n_gates_q)) begin
            err_d = 1'b1;
          end
          // The transfer that fills the table ends LOAD whatever gate_last says.
          if (gate_last || (({1'b0, n_gates_q} + 5'd1) == 5'(MAX_GATES))) begin
            state_d = EVAL;
            m_d     = 4'd0;
            if ((out_sel_q >= 4'd4) && (out_sel_q < 4'd12) &&
                ({1'b0, out_sel_q} >= ({1'b0, n_gates_q} + 5'd5))) begin
              err_d = 1'b1;
            end
          end
        end
      end
      EVAL: begin
        run_match_d = run_match_q & ~mismatch;
        m_d         = m_q + 4'd1;
        if (m_q == 4'd15) begin
          match_d = run_match_d & ~err_q;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tt_q        <= '0;
      out_sel_q   <= '0;
      out_inv_q   <= 1'b0;
      n_gates_q   <= '0;
      m_q         <= '0;
      run_match_q <= 1'b0;
      match_q     <= 1'b0;
      err_q       <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        gates_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      tt_q        <= tt_d;
      out_sel_q   <= out_sel_d;
      out_inv_q   <= out_inv_d;
      n_gates_q   <= n_gates_d;
      m_q         <= m_d;
      run_match_q <= run_match_d;
      match_q     <= match_d;
      err_q       <= err_d;
      gates_q     <= gates_d;
    end
  end

  assign gate_ready = (state_q == LOAD);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign match      = match_q;
  assign err        = err_q;
  assign n_gates    = n_gates_q;

`ifdef MAJ_CHECK_CEX_EN
  logic       cex_valid_q, cex_valid_d;
  logic [3:0] cex_idx_q, cex_idx_d;

  // Hold the first mismatching minterm; flag it once the last minterm is judged.
  always_comb begin
    cex_valid_d = cex_valid_q;
    cex_idx_d   = cex_idx_q;
    if ((state_q == IDLE) && start) begin
      cex_valid_d = 1'b0;
      cex_idx_d   = 4'd0;
    end else if (state_q == EVAL) begin
      if (mismatch && run_match_q) begin
        cex_idx_d = m_q;
      end
      if ((m_q == 4'd15) && (mismatch || !run_match_q)) begin
        cex_valid_d = 1'b1;
      end
    end
  end

  // Counterexample registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cex_valid_q <= 1'b0;
      cex_idx_q   <= 4'd0;
    end else begin
      cex_valid_q <= cex_valid_d;
      cex_idx_q   <= cex_idx_d;
    end
  end

  assign cex_valid = cex_valid_q;
  assign cex_idx   = cex_idx_q;
`else
  assign cex_valid = 1'b0;
  assign cex_idx   = 4'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_maj_chain_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_maj_chain_checker                                         |
// | Description : Scoreboard bench for maj_chain_checker. Expected results are |
// |               queued when a check is launched and compared at done.        |
// |               Honours MAJ_CHECK_CEX_EN for the counterexample outputs.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_maj_chain_checker;

`ifdef MAJ_CHECK_CEX_EN
  localparam bit CEX_EN = 1'b1;
`else
  localparam bit CEX_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] tt;
  logic [3:0]  out_sel;
  logic        out_inv;
  logic        gate_valid;
  logic        gate_ready;
  logic [14:0] gate_data;
  logic        gate_last;
  logic        busy;
  logic        done;
  logic        match;
  logic        err;
  logic [3:0]  n_gates;
  logic        cex_valid;
  logic [3:0]  cex_idx;

  maj_chain_checker #(.MAX_GATES(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .tt         (tt),
    .out_sel    (out_sel),
    .out_inv    (out_inv),
    .gate_valid (gate_valid),
    .gate_ready (gate_ready),
    .gate_data  (gate_data),
    .gate_last  (gate_last),
    .busy       (busy),
    .done       (done),
    .match      (match),
    .err        (err),
    .n_gates    (n_gates),
    .cex_valid  (cex_valid),
    .cex_idx    (cex_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct packed {
    logic       match;
    logic       err;
    logic [3:0] n;
    logic       chk_cex;
    logic       cv;
    logic [3:0] ci;
  } exp_t;

  exp_t        sb[$];
  logic [14:0] gq [8];

  function automatic exp_t mk_exp(input logic m, input logic e, input int n,
                                  input logic chk, input logic cv, input int ci);
    exp_t r;
    r.match   = m;
    r.err     = e;
    r.n       = 4'(n);
    r.chk_cex = chk;
    r.cv      = CEX_EN ? cv : 1'b0;
    r.ci      = CEX_EN ? 4'(ci) : 4'd0;
    return r;
  endfunction

  function automatic logic [14:0] gate(input logic [4:0] a, input logic [4:0] b,
                                       input logic [4:0] c);
    return {c, b, a};
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a + b + c) >= 2;
  endfunction

  // Reference truth table of the loaded netlist (legal chains only).
  function automatic logic [15:0] model_tt(input logic [3:0] os, input logic oi, input int ng);
    logic [15:0] f;
    logic [15:0] v;
    logic [4:0]  a, b, c;
    f = '0;
    for (int m = 0; m < 16; m++) begin
      v = '0;
      v[3:0] = 4'(m);
      for (int k = 0; k < ng; k++) begin
        a = gq[k][4:0];
        b = gq[k][9:5];
        c = gq[k][14:10];
        v[4+k] = maj3(v[a[3:0]] ^ a[4], v[b[3:0]] ^ b[4], v[c[3:0]] ^ c[4]);
      end
      f[m] = v[os] ^ oi;
    end
    return f;
  endfunction

  function automatic logic [4:0] rand_op(input int k);
    logic [3:0] idx;
    if ($urandom_range(0, 3) == 0) idx = 4'(12 + $urandom_range(0, 3));
    else                           idx = 4'($urandom_range(0, 3 + k));
    return {1'($urandom_range(0, 1)), idx};
  endfunction

  task automatic start_and_load(input logic [15:0] t, input logic [3:0] os, input logic oi,
                                input int ng, input bit use_last, input bit stall,
                                output int xfer_c, output bit ok);
    int w;
    ok = 1'b1;
    xfer_c = 0;
    tt = t; out_sel = os; out_inv = oi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < ng; k++) begin
      if (stall && k > 0) begin
        gate_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        n_vec++;
        if (gate_ready !== 1'b1 || n_gates !== 4'(k)) begin
          n_miss++;
          $display("FAIL stall_hold: gate_ready=%b n_gates=%0d, want gate_ready=1 n_gates=%0d",
                   gate_ready, n_gates, k);
        end
      end
      gate_data  = gq[k];
      gate_last  = use_last && (k == ng - 1);
      gate_valid = 1'b1;
      w = 0;
      while (!gate_ready && w < 8) begin @(posedge clk); #1; w++; end
      if (!gate_ready) begin
        n_vec++; n_miss++;
        $display("FAIL ready_timeout: gate_ready=0 for 8 cycles, want 1");
        gate_valid = 1'b0;
        ok = 1'b0;
        return;
      end
      xfer_c = cyc;
      @(posedge clk); #1;
    end
    gate_valid = 1'b0;
    gate_last  = 1'b0;
  endtask

  task automatic wait_done(input string name, input int xfer_c, input bit poke);
    int          w;
    exp_t        e;
    logic [15:0] t_save;
    w = 0;
    t_save = tt;
    while (!done && w < 40) begin
      if (poke && w == 3) begin
        t_save = tt; tt = ~tt; start = 1'b1;
        n_vec++;
        if (busy !== 1'b1) begin
          n_miss++;
          $display("FAIL %s_busy_eval: busy=%b, want 1", name, busy);
        end
      end
      if (poke && w == 4) begin start = 1'b0; tt = t_save; end
      @(posedge clk); #1;
      w++;
    end
    start = 1'b0;
    n_vec++;
    if (!done) begin
      n_miss++;
      $display("FAIL %s_done_timeout: done=0 after 40 cycles, want 1", name);
      return;
    end
    if (cyc - xfer_c != 17) begin
      n_miss++;
      $display("FAIL %s_latency: done at %0d cycles, want 17", name, cyc - xfer_c);
    end
    n_vec++;
    if (sb.size() == 0) begin
      n_miss++;
      $display("FAIL %s_scoreboard: queue empty at done, want one entry", name);
      return;
    end
    e = sb.pop_front();
    n_vec++;
    if (match !== e.match || err !== e.err || n_gates !== e.n) begin
      n_miss++;
      $display("FAIL %s_result: match=%b err=%b n_gates=%0d, want match=%b err=%b n_gates=%0d",
               name, match, err, n_gates, e.match, e.err, e.n);
    end
    if (e.chk_cex) begin
      n_vec++;
      if (cex_valid !== e.cv || cex_idx !== e.ci) begin
        n_miss++;
        $display("FAIL %s_cex: cex_valid=%b cex_idx=%0d, want cex_valid=%b cex_idx=%0d",
                 name, cex_valid, cex_idx, e.cv, e.ci);
      end
    end
    @(posedge clk); #1;
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0 || match !== e.match || err !== e.err) begin
      n_miss++;
      $display("FAIL %s_after_done: done=%b busy=%b match=%b err=%b, want 0 0 %b %b",
               name, done, busy, match, err, e.match, e.err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    n_vec++;
    if ({gate_ready, busy, done, match, err, n_gates, cex_valid, cex_idx} !== '0) begin
      n_miss++;
      $display("FAIL reset_outputs: rdy=%b busy=%b done=%b match=%b err=%b n=%0d cv=%b ci=%0d, want all 0",
               gate_ready, busy, done, match, err, n_gates, cex_valid, cex_idx);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_idle_ignore();
    gate_valid = 1'b1;
    gate_data  = 15'h1234;
    repeat (2) begin @(posedge clk); #1; end
    n_vec++;
    if (gate_ready !== 1'b0 || n_gates !== 4'd0 || busy !== 1'b0) begin
      n_miss++;
      $display("FAIL idle_ignore: gate_ready=%b n_gates=%0d busy=%b, want 0 0 0",
               gate_ready, n_gates, busy);
    end
    gate_valid = 1'b0;
  endtask

  task automatic run_one(input string name, input logic [15:0] t, input logic [3:0] os,
                         input logic oi, input int ng, input bit use_last, input bit stall,
                         input bit poke, input exp_t e);
    int xc;
    bit ok;
    sb.push_back(e);
    start_and_load(t, os, oi, ng, use_last, stall, xc, ok);
    if (ok) wait_done(name, xc, poke);
    else    void'(sb.pop_back());
  endtask

  // MAJ(x0,x1,x2) is 1 at minterms 3,5,6,7 of each byte -> 0xE8E8.
  task automatic test_match();
    gq[0] = gate(5'd0, 5'd1, 5'd2);
    run_one("match", 16'hE8E8, 4'd4, 1'b0, 1, 1'b1, 1'b0, 1'b0, mk_exp(1, 0, 1, 1, 0, 0));
  endtask

  task automatic test_mismatch();
    gq[0] = gate(5'd0, 5'd1, 5'd2);
    run_one("mismatch", 16'hE8E9, 4'd4, 1'b0, 1, 1'b1, 1'b0, 1'b0, mk_exp(0, 0, 1, 1, 1, 0));
  endtask

  task automatic test_self_ref();
    gq[0] = gate(5'd0, 5'd1, 5'd4);
    run_one("self_ref", 16'hE8E8, 4'd4, 1'b0, 1, 1'b1, 1'b0, 1'b0, mk_exp(0, 1, 1, 0, 0, 0));
  endtask

  task automatic test_out_sel_fwd();
    gq[0] = gate(5'd0, 5'd1, 5'd2);
    run_one("out_sel_fwd", 16'hE8E8, 4'd5, 1'b0, 1, 1'b1, 1'b0, 1'b0, mk_exp(0, 1, 1, 0, 0, 0));
  endtask

  // Gate k>0 = MAJ(gate k-1, 1, 0) = gate k-1, so gate 7 still equals 0xE8E8.
  task automatic test_max_gates();
    gq[0] = gate(5'd0, 5'd1, 5'd2);
    for (int k = 1; k < 8; k++) gq[k] = gate(5'(4 + k - 1), 5'h1C, 5'h0C);
    run_one("max_gates", 16'hE8E8, 4'd11, 1'b0, 8, 1'b0, 1'b1, 1'b0, mk_exp(1, 0, 8, 1, 0, 0));
  endtask

  task automatic test_reset_mid_eval();
    int xc;
    bit ok;
    gq[0] = gate(5'd0, 5'd1, 5'd2);
    start_and_load(16'hE8E8, 4'd4, 1'b0, 1, 1'b1, 1'b0, xc, ok);
    if (ok) begin
      repeat (7) begin @(posedge clk); #1; end
      n_vec++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_miss++;
        $display("FAIL rst_eval_pre: busy=%b done=%b, want 1 0", busy, done);
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      n_vec++;
      if ({gate_ready, busy, done, match, err, n_gates, cex_valid, cex_idx} !== '0) begin
        n_miss++;
        $display("FAIL rst_eval_post: rdy=%b busy=%b done=%b match=%b err=%b n=%0d, want all 0",
                 gate_ready, busy, done, match, err, n_gates);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
    end
    run_one("after_rst", 16'hFF00, 4'd3, 1'b0, 1, 1'b1, 1'b0, 1'b0, mk_exp(1, 0, 1, 1, 0, 0));
  endtask

  task automatic test_start_ignored();
    gq[0] = gate(5'd0, 5'd1, 5'd2);
    run_one("start_ign", 16'h5555, 4'd0, 1'b1, 1, 1'b1, 1'b0, 1'b1, mk_exp(1, 0, 1, 1, 0, 0));
  endtask

  task automatic test_back_to_back();
    int          ng, bitpos;
    logic [3:0]  os;
    logic        oi;
    logic [15:0] f;
    bit          good;
    for (int it = 0; it < 6; it++) begin
      ng = $urandom_range(1, 8);
      for (int k = 0; k < ng; k++) gq[k] = gate(rand_op(k), rand_op(k), rand_op(k));
      if ($urandom_range(0, 3) == 0) os = 4'($urandom_range(12, 15));
      else                           os = 4'($urandom_range(0, 3 + ng));
      oi     = 1'($urandom_range(0, 1));
      f      = model_tt(os, oi, ng);
      good   = (it % 2 == 0);
      bitpos = $urandom_range(0, 15);
      if (!good) f = f ^ (16'h1 << bitpos);
      run_one("b2b", f, os, oi, ng, (ng < 8) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0, 1'b0,
              mk_exp(good, 0, ng, 1, !good, good ? 0 : bitpos));
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; tt = '0; out_sel = '0; out_inv = 1'b0;
    gate_valid = 1'b0; gate_data = '0; gate_last = 1'b0;
    for (int i = 0; i < 8; i++) gq[i] = '0;
    test_reset();
    test_idle_ignore();
    test_match();
    test_mismatch();
    test_self_ref();
    test_out_sel_fwd();
    test_max_gates();
    test_reset_mid_eval();
    test_start_ignored();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
